// File: rtl/mtx_pkg.sv
// Shared types, default sizing and lane helpers for the stream-to-matrix packer.
package mtx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam int DEF_DIM = 32;
  localparam int DIM_W   = $clog2(DEF_DIM) + 1;
  localparam int CNT_W   = $clog2(DEF_DIM * DEF_DIM) + 1;

  // Lane 0 sits in the MSBs of the input word and is the first pixel in stream order.
  function automatic int lane_lsb(input int lane, input int lanes, input int bits);
    return (lanes - 1 - lane) * bits;
  endfunction

endpackage

// File: rtl/mtx_lane_addr.sv
// Per-lane row/col generation for one input word, built from a chain of wrap incrementers.
module mtx_lane_addr
  import mtx_pkg::*;
#(
  parameter int LANES = 4,
  parameter int AW    = 5,
  parameter int DW    = 6,
  parameter int CW    = 11
) (
  input  logic [DW-1:0] row_i,
  input  logic [DW-1:0] col_i,
  input  logic [DW-1:0] n_i,
  input  logic [CW-1:0] rem_i,
  output logic [AW-1:0] lane_row [LANES],
  output logic [AW-1:0] lane_col [LANES],
  output logic [LANES-1:0] lane_we,
  output logic [DW-1:0] next_row,
  output logic [DW-1:0] next_col,
  output logic [CW-1:0] wr_cnt
);

  logic [DW-1:0] r;
  logic [DW-1:0] c;
  logic [CW-1:0] cnt;

  always_comb begin
    r       = row_i;
    c       = col_i;
    cnt     = '0;
    lane_we = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_row[k] = r[AW-1:0];
      lane_col[k] = c[AW-1:0];
      lane_we[k]  = (CW'(k) < rem_i);
      // Only lanes that land inside the matrix move the pointers.
      if (lane_we[k]) begin
        cnt = cnt + CW'(1);
        if (c + DW'(1) == n_i) begin
          c = '0;
          r = r + DW'(1);
        end else begin
          c = c + DW'(1);
        end
      end
    end
    next_row = r;
    next_col = c;
    wr_cnt   = cnt;
  end

endmodule

// File: rtl/mtx_stream_packer.sv
// Scatters a valid/ready stream of packed pixel words row-major into an m x n matrix register.
//   state | meaning
//   IDLE  | no active fill; matrix holds last contents, in_ready low
//   FILL  | accepting words; pixels written at the row/col pointer chain
//   FULL  | all m*n pixels written; matrix stable until release or start
module mtx_stream_packer
  import mtx_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DIM   = DEF_DIM,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DIM):0]     m,
  input  logic [$clog2(DIM):0]     n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*BITS-1:0]    in_data,
  input  logic                     release_mtx,
  output logic [BITS-1:0]          OUT [DIM][DIM],
  output logic                     full,
  output logic                     err,
  output logic [$clog2(DIM*DIM):0] pix_cnt
);

  localparam int DW = $clog2(DIM) + 1;
  localparam int CW = $clog2(DIM * DIM) + 1;
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  state_e state_q, state_d;
  logic [DW-1:0] m_q, m_d, n_q, n_d;
  logic [DW-1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] pix_q, pix_d, rem_q, rem_d;
  logic full_q, full_d, err_q, err_d, rdy_q, rdy_d;
  logic [BITS-1:0] out_q [DIM][DIM];
  logic [BITS-1:0] out_d [DIM][DIM];

  logic [AW-1:0] lane_row [LANES];
  logic [AW-1:0] lane_col [LANES];
  logic [LANES-1:0] lane_we;
  logic [DW-1:0] next_row, next_col;
  logic [CW-1:0] wr_cnt;
  logic [2*DW-1:0] area;
  logic legal;

  mtx_lane_addr #(
    .LANES (LANES),
    .AW    (AW),
    .DW    (DW),
    .CW    (CW)
  ) u_lane_addr (
    .row_i    (row_q),
    .col_i    (col_q),
    .n_i      (n_q),
    .rem_i    (rem_q),
    .lane_row (lane_row),
    .lane_col (lane_col),
    .lane_we  (lane_we),
    .next_row (next_row),
    .next_col (next_col),
    .wr_cnt   (wr_cnt)
  );

  assign legal = (m != '0) && (m <= DW'(DIM)) && (n != '0) && (n <= DW'(DIM));
  // Evaluated once per start to seed the remaining-pixel down-counter.
  assign area  = {{DW{1'b0}}, m} * {{DW{1'b0}}, n};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_d   = pix_q;
    rem_d   = rem_q;
    full_d  = full_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
    out_d   = out_q;

    if (start && legal) begin
      // A legal start wins over release and over a same-cycle data beat.
      state_d = FILL;
      m_d     = m;
      n_d     = n;
      row_d   = '0;
      col_d   = '0;
      pix_d   = '0;
      rem_d   = CW'(area);
      full_d  = 1'b0;
      err_d   = 1'b0;
      rdy_d   = 1'b1;
      out_d   = '{default: '0};
    end else begin
      if (start) begin
        err_d = 1'b1;
      end
      case (state_q)
        FILL: begin
          if (in_valid && rdy_q) begin
            for (int k = 0; k < LANES; k++) begin
              if (lane_we[k]) begin
                out_d[lane_row[k]][lane_col[k]] = in_data[lane_lsb(k, LANES, BITS) +: BITS];
              end
            end
            pix_d = pix_q + wr_cnt;
            rem_d = rem_q - wr_cnt;
            row_d = next_row;
            col_d = next_col;
            // The last pixel always wraps the pointer to (m, 0).
            if (next_row == m_q) begin
              state_d = FULL;
              full_d  = 1'b1;
              rdy_d   = 1'b0;
            end
          end
        end
        FULL: begin
          if (release_mtx) begin
            state_d = IDLE;
            full_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      rem_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      out_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      rem_q   <= rem_d;
      full_q  <= full_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      out_q   <= out_d;
    end
  end

  assign OUT      = out_q;
  assign in_ready = rdy_q;
  assign full     = full_q;
  assign err      = err_q;
  assign pix_cnt  = pix_q;

endmodule

// File: doc/mtx_stream_packer.md
Name: mtx_stream_packer

Overview:
- Parametrised successor to the column-to-matrix packer in the accelerator front end.
- Accepts a stream of packed pixel words under a valid/ready handshake and scatters them row-major into an m x n feature-map matrix, up to DIM x DIM.
- Adds explicit start/release control, zero-fill of unwritten cells, a configurable lane count, dimension checking and backpressure.
- Feeds the convolution engine's matrix input.

Parameters:
- BITS, 8, bits per pixel.
- DIM, 32, maximum rows and columns of any feature map.
- LANES, 4, pixels packed per input word (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse: latch m/n, zero the matrix, begin filling.
- m  in  $clog2(DIM)+1  row count, latched on start.
- n  in  $clog2(DIM)+1  column count, latched on start.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  LANES*BITS  packed pixels; lane 0 = MSBs = first pixel.
- release  in  1  consumer done with matrix; return to idle.
- OUT  out  BITS x [DIM][DIM]  matrix, OUT[row][col].
- full  out  1  all m*n pixels written.
- err  out  1  last start carried illegal dimensions.
- pix_cnt  out  $clog2(DIM*DIM)+1  pixels written so far.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; OUT all zero; full=0; err=0; pix_cnt=0; in_ready=0.
  - Latched m/n = 0; row/col pointers = 0.
- States:
  - IDLE: in_ready=0. On start with 1<=m<=DIM and 1<=n<=DIM:
    - latch m/n; zero every OUT cell (whole DIM x DIM); clear pix_cnt and pointers; err=0; go FILL next cycle.
  - IDLE, illegal start (m or n = 0 or > DIM): err=1; stay IDLE; OUT untouched.
  - FILL: in_ready=1.
    - On in_valid&in_ready, lane k is written to position pix_cnt+k (row-major, row = pos / n, col = pos % n), for every k with pix_cnt+k < m*n.
    - Lanes beyond m*n are discarded.
    - pix_cnt += number of lanes written.
    - When pix_cnt reaches m*n: go FULL; full=1 on the same edge the last pixel lands.
  - FULL: in_ready=0; OUT stable; full=1. On release: go IDLE, full=0, OUT retained.
- Latency: a word accepted on edge t is visible on OUT after edge t; full is asserted after the same edge.
- Row wrap: pointers advance by col += 1 per lane, wrapping to col=0, row+1 at col=n-1. A single word may span up to ceil(LANES/n)+1 rows when n < LANES. No multipliers: per-lane positions come from the incremental pointer chain.
- Cells outside m x n always read 0 after start.
- Simultaneous events:
  - start in FILL or FULL aborts and restarts: zero, relatch, FILL. start wins over release and over a same-cycle data beat, which is dropped and not counted.
  - release outside FULL is ignored.
  - in_valid while in_ready=0 is not consumed; the producer must hold it.
- rst mid-fill: immediate clear to reset values, no partial matrix retained.
- pix_cnt width covers DIM*DIM exactly (1024 for defaults), with no overflow.

Decomposition:
- Package mtx_pkg:
  - state enum {IDLE, FILL, FULL}.
  - localparams DIM_W=$clog2(DIM)+1 and CNT_W=$clog2(DIM*DIM)+1.
  - lane-slice helper function.
- Sub-module mtx_lane_addr (combinational):
  - inputs: current row/col, n, remaining pixel count.
  - outputs: per-lane row, col, write-enable, next row/col.
  - chains LANES wrap incrementers.
- Top holds the FSM, counter and OUT register array.

Test Plan:
- m=4,n=4,LANES=4: start, 4 words 0x01020304..0x0D0E0F10 back-to-back -> OUT[r][c]=4r+c+1; full after 4th beat; in_ready=0 after.
- m=3,n=5 (15 px), 4 words, last word 0xAABBCCDD -> OUT[2][2..4]=AA,BB,CC; DD dropped; pix_cnt=15; OUT[3][0]=0.
- m=2,n=3, in_valid toggling every other cycle -> only accepted beats written; order correct; full after 2 accepted beats.
- Fill 2x2 to full, then start with m=0 -> err=1, OUT and full unchanged; release -> IDLE, full=0.
- Mid-fill of 8x8 after 3 beats, start with m=n=2 -> all OUT zero next cycle; fresh fill of 1 beat gives full.
- rst asserted mid-fill, asynchronously between edges -> OUT, pix_cnt, full cleared immediately; in_ready=0.
